// File: rtl/frame_timing_controller_pkg.sv
// Shared types and constants for the frame timing controller.
//   state_t : controller FSM states (LS/LE only reachable with LINE_SHORT_PKT_EN)
//   SP_*    : CSI-2 short-packet type codes carried on sp_type_o
//   count_t : 12-bit line / pixel count
package csi2_timing_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FS,
    ST_LINE,
    ST_HBLANK,
    ST_FE,
    ST_VBLANK,
    ST_LS,
    ST_LE
  } state_t;

  localparam logic [1:0] SP_FS = 2'b00;
  localparam logic [1:0] SP_FE = 2'b01;
  localparam logic [1:0] SP_LS = 2'b10;
  localparam logic [1:0] SP_LE = 2'b11;

  typedef logic [11:0] count_t;

  // Wide enough for any blanking length up to 65536 cycles.
  localparam int BLANK_W = 16;

endpackage

// File: rtl/frame_timing_controller_if.sv
// Handshake and timing bus between the frame timing controller (master)
// and the pattern generator / CSI-2 packetiser pair (slave).
//   sp_valid_o / sp_type_o / sp_ready_i : short-packet request handshake
//   pix_valid_o / pix_ready_i           : pixel-beat handshake
//   line_last_o                         : current beat closes the line
//   line_number_o / hori_pixel_count_o  : generator coordinates
//   pattern_o                           : generator pattern select
interface frame_timing_controller_if;
  import csi2_timing_pkg::*;

  logic       sp_valid_o;
  logic [1:0] sp_type_o;
  logic       sp_ready_i;
  logic       pix_valid_o;
  logic       pix_ready_i;
  logic       line_last_o;
  count_t     line_number_o;
  count_t     hori_pixel_count_o;
  logic [2:0] pattern_o;

  modport master (
    output sp_valid_o, sp_type_o, pix_valid_o, line_last_o,
           line_number_o, hori_pixel_count_o, pattern_o,
    input  sp_ready_i, pix_ready_i
  );

  modport slave (
    input  sp_valid_o, sp_type_o, pix_valid_o, line_last_o,
           line_number_o, hori_pixel_count_o, pattern_o,
    output sp_ready_i, pix_ready_i
  );

endinterface

// File: rtl/frame_timing_controller_blank_cycle_counter.sv
// Loadable down-counter timing the horizontal and vertical blanking gaps.
//   clk, rst   : clock, asynchronous active-high reset
//   run        : high while a blanking state is active; low keeps it preloaded
//   load_value : blanking length minus one, captured while run is low
//   done       : high in the final cycle of the blanking gap
module blank_cycle_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Preloading while idle means the count is already correct on the first
  // blanking cycle, so a gap of N cycles needs no extra setup cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!run) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = run && (count == '0);

endmodule

// File: rtl/frame_timing_controller.sv
// Frame timing controller: sequences FS, active lines, horizontal blanking,
// FE and vertical blanking for the test-pattern generator and CSI-2
// packetiser, and advances the pattern every FRAMES_PER_PATTERN frames.
//   byte_clk_i    : clock
//   reset_i       : asynchronous active-high reset
//   enable_i      : run frames continuously; a drop finishes the current frame
//   bus           : master side of frame_timing_controller_if
//   frame_count_o : completed frames (wraps)
//   busy_o        : controller is not idle
// Optional build macro LINE_SHORT_PKT_EN frames every line with LS/LE packets.
module frame_timing_controller
  import csi2_timing_pkg::*;
#(
  parameter int H_ACTIVE           = 2040,
  parameter int V_ACTIVE           = 2464,
  parameter int PIX_PER_CLK        = 4,
  parameter int H_BLANK_CLKS       = 64,
  parameter int V_BLANK_CLKS       = 4096,
  parameter int FRAMES_PER_PATTERN = 42,
  parameter int NUM_PATTERNS       = 4
) (
  input  logic                      byte_clk_i,
  input  logic                      reset_i,
  input  logic                      enable_i,
  frame_timing_controller_if.master bus,
  output logic [15:0]               frame_count_o,
  output logic                      busy_o
);

  localparam count_t              STEP          = count_t'(PIX_PER_CLK);
  localparam count_t              LAST_HORI     = count_t'(H_ACTIVE - PIX_PER_CLK);
  localparam count_t              LAST_LINE     = count_t'(V_ACTIVE);
  localparam logic                SINGLE_BEAT   = (H_ACTIVE == PIX_PER_CLK);
  localparam logic [2:0]          LAST_PATTERN  = 3'(NUM_PATTERNS - 1);
  localparam logic [15:0]         LAST_FIP      = 16'(FRAMES_PER_PATTERN - 1);
  localparam logic [BLANK_W-1:0]  H_LOAD        = BLANK_W'(H_BLANK_CLKS - 1);
  localparam logic [BLANK_W-1:0]  V_LOAD        = BLANK_W'(V_BLANK_CLKS - 1);

  state_t               state;
  logic [15:0]          frame_in_pattern;
  logic                 blank_run;
  logic                 blank_done;
  logic [BLANK_W-1:0]   blank_load;
  logic                 sp_fire;
  logic                 pix_fire;

  assign sp_fire   = bus.sp_valid_o && bus.sp_ready_i;
  assign pix_fire  = bus.pix_valid_o && bus.pix_ready_i;
  assign blank_run = (state == ST_HBLANK) || (state == ST_VBLANK);
  // FE is the only state that precedes VBLANK, so it selects the long preload.
  assign blank_load = (state == ST_FE) ? V_LOAD : H_LOAD;

  blank_cycle_counter #(
    .WIDTH (BLANK_W)
  ) u_blank (
    .clk        (byte_clk_i),
    .rst        (reset_i),
    .run        (blank_run),
    .load_value (blank_load),
    .done       (blank_done)
  );

  // All outputs are registered and set on the transition into the state
  // that owns them, so valid/type never glitch and stay put under stalls.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below sees the pre-edge values regardless of statement order.
  always_ff @(posedge byte_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state                  <= ST_IDLE;
      frame_in_pattern       <= '0;
      bus.sp_valid_o         <= 1'b0;
      bus.sp_type_o          <= SP_FS;
      bus.pix_valid_o        <= 1'b0;
      bus.line_last_o        <= 1'b0;
      bus.line_number_o      <= '0;
      bus.hori_pixel_count_o <= '0;
      bus.pattern_o          <= '0;
      frame_count_o          <= '0;
      busy_o                 <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable_i) begin
            state                  <= ST_FS;
            busy_o                 <= 1'b1;
            bus.sp_valid_o         <= 1'b1;
            bus.sp_type_o          <= SP_FS;
            bus.line_number_o      <= count_t'(1);
            bus.hori_pixel_count_o <= '0;
          end
        end

        ST_FS: begin
          if (sp_fire) begin
`ifdef LINE_SHORT_PKT_EN
            // sp_valid_o stays high: the LS request follows back to back.
            state           <= ST_LS;
            bus.sp_type_o   <= SP_LS;
`else
            state           <= ST_LINE;
            bus.sp_valid_o  <= 1'b0;
            bus.pix_valid_o <= 1'b1;
            bus.line_last_o <= SINGLE_BEAT;
`endif
          end
        end

`ifdef LINE_SHORT_PKT_EN
        ST_LS: begin
          if (sp_fire) begin
            state           <= ST_LINE;
            bus.sp_valid_o  <= 1'b0;
            bus.pix_valid_o <= 1'b1;
            bus.line_last_o <= SINGLE_BEAT;
          end
        end

        ST_LE: begin
          if (sp_fire) begin
            state          <= ST_HBLANK;
            bus.sp_valid_o <= 1'b0;
          end
        end
`endif

        ST_LINE: begin
          if (pix_fire) begin
            if (bus.line_last_o) begin
              bus.pix_valid_o        <= 1'b0;
              bus.line_last_o        <= 1'b0;
              bus.hori_pixel_count_o <= '0;
`ifdef LINE_SHORT_PKT_EN
              state                  <= ST_LE;
              bus.sp_valid_o         <= 1'b1;
              bus.sp_type_o          <= SP_LE;
`else
              state                  <= ST_HBLANK;
`endif
            end else begin
              bus.hori_pixel_count_o <= bus.hori_pixel_count_o + STEP;
              bus.line_last_o        <= (bus.hori_pixel_count_o + STEP) == LAST_HORI;
            end
          end
        end

        ST_HBLANK: begin
          if (blank_done) begin
            if (bus.line_number_o < LAST_LINE) begin
              bus.line_number_o <= bus.line_number_o + count_t'(1);
`ifdef LINE_SHORT_PKT_EN
              state             <= ST_LS;
              bus.sp_valid_o    <= 1'b1;
              bus.sp_type_o     <= SP_LS;
`else
              state             <= ST_LINE;
              bus.pix_valid_o   <= 1'b1;
              bus.line_last_o   <= SINGLE_BEAT;
`endif
            end else begin
              state          <= ST_FE;
              bus.sp_valid_o <= 1'b1;
              bus.sp_type_o  <= SP_FE;
            end
          end
        end

        ST_FE: begin
          if (sp_fire) begin
            state             <= ST_VBLANK;
            bus.sp_valid_o    <= 1'b0;
            bus.line_number_o <= '0;
            frame_count_o     <= frame_count_o + 16'd1;
            // Pattern only moves here, between frames.
            if (frame_in_pattern == LAST_FIP) begin
              frame_in_pattern <= '0;
              bus.pattern_o    <= (bus.pattern_o == LAST_PATTERN) ? 3'd0
                                                                  : bus.pattern_o + 3'd1;
            end else begin
              frame_in_pattern <= frame_in_pattern + 16'd1;
            end
          end
        end

        ST_VBLANK: begin
          if (blank_done) begin
            if (enable_i) begin
              state                  <= ST_FS;
              bus.sp_valid_o         <= 1'b1;
              bus.sp_type_o          <= SP_FS;
              bus.line_number_o      <= count_t'(1);
              bus.hori_pixel_count_o <= '0;
            end else begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_timing_controller.sv
// Directed bench for frame_timing_controller on a small configuration:
// 8x3 active, 4 pixels per beat, 2-cycle HBLANK, 5-cycle VBLANK,
// 2 frames per pattern, 4 patterns.
module tb_frame_timing_controller;
  import csi2_timing_pkg::*;

  localparam int H   = 8;
  localparam int V   = 3;
  localparam int P   = 4;
  localparam int HB  = 2;
  localparam int VB  = 5;
  localparam int FPP = 2;
  localparam int NP  = 4;

  logic        byte_clk_i = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic [15:0] frame_count_o;
  logic        busy_o;

  frame_timing_controller_if bus ();

  frame_timing_controller #(
    .H_ACTIVE           (H),
    .V_ACTIVE           (V),
    .PIX_PER_CLK        (P),
    .H_BLANK_CLKS       (HB),
    .V_BLANK_CLKS       (VB),
    .FRAMES_PER_PATTERN (FPP),
    .NUM_PATTERNS       (NP)
  ) dut (
    .byte_clk_i    (byte_clk_i),
    .reset_i       (reset_i),
    .enable_i      (enable_i),
    .bus           (bus),
    .frame_count_o (frame_count_o),
    .busy_o        (busy_o)
  );

  always #5 byte_clk_i = ~byte_clk_i;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cyc    = 0;
  bit rand_ready = 1'b0;

  // Handshake log, stamped with the sample index at which the transfer was offered and taken.
  int sp_type_q[$];
  int sp_cyc_q[$];
  int beat_line_q[$];
  int beat_hori_q[$];
  int beat_last_q[$];
  int beat_cyc_q[$];
  int frame_beats_q[$];
  int pattern_q[$];
  int beats_this_frame = 0;
  int fe_cyc = 0;

  logic       prev_sp_valid, prev_sp_ready, prev_pix_valid, prev_pix_ready;
  logic       prev_last, prev_fe_fire;
  logic [1:0] prev_sp_type;
  count_t     prev_line, prev_hori;
  logic [2:0] prev_pattern;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_prev();
    prev_sp_valid  = 1'b0;
    prev_sp_ready  = 1'b1;
    prev_pix_valid = 1'b0;
    prev_pix_ready = 1'b1;
    prev_last      = 1'b0;
    prev_fe_fire   = 1'b0;
    prev_sp_type   = 2'b00;
    prev_line      = '0;
    prev_hori      = '0;
    prev_pattern   = 3'd0;
  endtask

  task automatic clear_logs();
    sp_type_q.delete();
    sp_cyc_q.delete();
    beat_line_q.delete();
    beat_hori_q.delete();
    beat_last_q.delete();
    beat_cyc_q.delete();
    frame_beats_q.delete();
    pattern_q.delete();
    beats_this_frame = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sp_valid"},  32'(bus.sp_valid_o), 0);
    check({tag, "_sp_type"},   32'(bus.sp_type_o), 0);
    check({tag, "_pix_valid"}, 32'(bus.pix_valid_o), 0);
    check({tag, "_line_last"}, 32'(bus.line_last_o), 0);
    check({tag, "_line"},      32'(bus.line_number_o), 0);
    check({tag, "_hori"},      32'(bus.hori_pixel_count_o), 0);
    check({tag, "_pattern"},   32'(bus.pattern_o), 0);
    check({tag, "_frames"},    32'(frame_count_o), 0);
    check({tag, "_busy"},      32'(busy_o), 0);
  endtask

  // One clock: sample outputs 1 time unit after the edge, check protocol
  // rules against the previous sample, drive readies, log transfers.
  task automatic tick();
    logic fe_fire;
    @(posedge byte_clk_i);
    #1;
    cyc++;
    if (bus.sp_valid_o || bus.pix_valid_o)
      check("valid_exclusive", 32'(bus.sp_valid_o && bus.pix_valid_o), 0);
    if (prev_sp_valid && !prev_sp_ready)
      check("sp_held", 32'({bus.sp_valid_o, bus.sp_type_o}), 32'({1'b1, prev_sp_type}));
    if (prev_pix_valid && !prev_pix_ready)
      check("pix_held",
            32'({bus.pix_valid_o, bus.line_last_o, bus.line_number_o, bus.hori_pixel_count_o}),
            32'({1'b1, prev_last, prev_line, prev_hori}));
    if (bus.pattern_o !== prev_pattern)
      check("pattern_only_at_fe", 32'(prev_fe_fire), 1);

    if (rand_ready) begin
      bus.sp_ready_i  = 1'($urandom_range(0, 1));
      bus.pix_ready_i = 1'($urandom_range(0, 1));
    end else begin
      bus.sp_ready_i  = 1'b1;
      bus.pix_ready_i = 1'b1;
    end

    fe_fire = 1'b0;
    if (bus.sp_valid_o && bus.sp_ready_i) begin
      sp_type_q.push_back(int'(bus.sp_type_o));
      sp_cyc_q.push_back(cyc);
      if (bus.sp_type_o == SP_FS) begin
        pattern_q.push_back(int'(bus.pattern_o));
        beats_this_frame = 0;
      end
      if (bus.sp_type_o == SP_FE) begin
        frame_beats_q.push_back(beats_this_frame);
        fe_cyc  = cyc;
        fe_fire = 1'b1;
      end
    end
    if (bus.pix_valid_o && bus.pix_ready_i) begin
      beat_line_q.push_back(int'(bus.line_number_o));
      beat_hori_q.push_back(int'(bus.hori_pixel_count_o));
      beat_last_q.push_back(int'(bus.line_last_o));
      beat_cyc_q.push_back(cyc);
      beats_this_frame++;
    end

    prev_sp_valid  = bus.sp_valid_o;
    prev_sp_ready  = bus.sp_ready_i;
    prev_sp_type   = bus.sp_type_o;
    prev_pix_valid = bus.pix_valid_o;
    prev_pix_ready = bus.pix_ready_i;
    prev_last      = bus.line_last_o;
    prev_line      = bus.line_number_o;
    prev_hori      = bus.hori_pixel_count_o;
    prev_pattern   = bus.pattern_o;
    prev_fe_fire   = fe_fire;
  endtask

`ifdef LINE_SHORT_PKT_EN
  localparam int N_SP = 8;
  int exp_sp[N_SP] = '{0, 2, 3, 2, 3, 2, 3, 1};
`else
  localparam int N_SP = 3;
  int exp_sp[N_SP] = '{0, 1, 0};
  int exp_sp_cyc[N_SP] = '{1, 14, 20};
`endif
  int exp_line[6] = '{1, 1, 2, 2, 3, 3};
  int exp_hori[6] = '{0, 4, 0, 4, 0, 4};
  int exp_last[6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_cyc;
    int n_sp;
    int n_fs;

    reset_i         = 1'b1;
    enable_i        = 1'b0;
    bus.sp_ready_i  = 1'b1;
    bus.pix_ready_i = 1'b1;
    clear_prev();
    #12;
    check_all_zero("reset");
    @(posedge byte_clk_i);
    #1;
    reset_i = 1'b0;

    // Idle with enable low: nothing starts.
    repeat (3) tick();
    check("idle_busy", 32'(busy_o), 0);
    check("idle_sp_valid", 32'(bus.sp_valid_o), 0);

    // Nominal frame, readies high.
    clear_logs();
    cyc = 0;
    enable_i = 1'b1;
    repeat (30) tick();
    check("sp_count", 32'(sp_type_q.size() >= N_SP), 1);
    for (int i = 0; i < N_SP; i++) begin
      check($sformatf("sp_type[%0d]", i), 32'(sp_type_q[i]), 32'(exp_sp[i]));
`ifndef LINE_SHORT_PKT_EN
      check($sformatf("sp_cyc[%0d]", i), 32'(sp_cyc_q[i]), 32'(exp_sp_cyc[i]));
`endif
    end
    for (int i = 0; i < 6; i++) begin
      check($sformatf("beat_line[%0d]", i), 32'(beat_line_q[i]), 32'(exp_line[i]));
      check($sformatf("beat_hori[%0d]", i), 32'(beat_hori_q[i]), 32'(exp_hori[i]));
      check($sformatf("beat_last[%0d]", i), 32'(beat_last_q[i]), 32'(exp_last[i]));
    end
`ifdef LINE_SHORT_PKT_EN
    check("first_beat_latency", 32'(beat_cyc_q[0]), 32'(sp_cyc_q[1] + 1));
`else
    check("first_beat_latency", 32'(beat_cyc_q[0]), 32'(sp_cyc_q[0] + 1));
`endif
    check("frame0_beats", 32'(frame_beats_q[0]), 6);

    // Random stalls over the pattern sequence.
    rand_ready = 1'b1;
    for (int i = 0; i < 4000 && frame_count_o < 16'd9; i++) tick();
    rand_ready = 1'b0;
    check("frames_reached", 32'(frame_count_o), 9);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("pattern[%0d]", i), 32'(pattern_q[i]), 32'((i / FPP) % NP));
      check($sformatf("frame_beats[%0d]", i), 32'(frame_beats_q[i]), 6);
    end

    // Drop enable during line 2 of frame 10.
    for (int i = 0; i < 200 && !(bus.pix_valid_o && bus.line_number_o == 12'd2); i++) tick();
    check("reached_line2", 32'(bus.pix_valid_o && bus.line_number_o == 12'd2), 1);
    enable_i = 1'b0;
    sp_type_q.delete();
    for (int i = 0; i < 200 && busy_o; i++) tick();
    idle_cyc = cyc;
    check("drop_busy", 32'(busy_o), 0);
    check("drop_last_fe", 32'(sp_type_q[$]), 32'(SP_FE));
    n_fs = 0;
    foreach (sp_type_q[i]) if (sp_type_q[i] == int'(SP_FS)) n_fs++;
    check("drop_no_fs", 32'(n_fs), 0);
    check("drop_frames", 32'(frame_count_o), 10);
    check("drop_vblank_len", 32'(idle_cyc - fe_cyc), 32'(VB + 1));
    n_sp = sp_type_q.size();
    repeat (10) tick();
    check("drop_stays_idle", 32'(busy_o), 0);
    check("drop_no_new_sp", 32'(sp_type_q.size()), 32'(n_sp));
    check("drop_line_zero", 32'(bus.line_number_o), 0);

    // Asynchronous reset in the middle of a line.
    enable_i = 1'b1;
    for (int i = 0; i < 50 && !bus.pix_valid_o; i++) tick();
    check("pre_reset_in_line", 32'(bus.pix_valid_o), 1);
    check("pre_reset_pattern", 32'(bus.pattern_o), 1);
    #3;
    reset_i = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(posedge byte_clk_i);
    #1;
    reset_i = 1'b0;
    clear_prev();
    clear_logs();
    cyc = 0;
    tick();
    check("restart_sp_valid", 32'(bus.sp_valid_o), 1);
    check("restart_sp_type", 32'(bus.sp_type_o), 32'(SP_FS));
    check("restart_line", 32'(bus.line_number_o), 1);
    check("restart_pattern", 32'(bus.pattern_o), 0);
    check("restart_frames", 32'(frame_count_o), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/frame_timing_controller.md
Name: frame_timing_controller

Overview:
- Sequences the test-pattern image generator and the CSI-2 packet path on byte_clk_i.
- Produces the 1-based line number and the 0-based horizontal pixel count that drive the generator, plus frame/line short-packet requests and a pixel-beat valid/ready handshake to the packetiser.
- Owns pattern selection: advances the pattern every FRAMES_PER_PATTERN frames.
- Sits between sensor-mode configuration and the generator/packetiser pair.

Parameters:
- H_ACTIVE, 2040: active pixels per line; must be a multiple of PIX_PER_CLK.
- V_ACTIVE, 2464: active lines per frame.
- PIX_PER_CLK, 4: pixels per accepted beat.
- H_BLANK_CLKS, 64: idle cycles after each line.
- V_BLANK_CLKS, 4096: idle cycles after the frame-end (FE) packet.
- FRAMES_PER_PATTERN, 42: frames shown per pattern.
- NUM_PATTERNS, 4: pattern count; pattern_o wraps to 0 after NUM_PATTERNS-1.

Ports:
- byte_clk_i in 1: clock.
- reset_i in 1: reset, asynchronous and active-high.
- enable_i in 1: run frames continuously. Deassertion completes the current frame, then goes idle.
- sp_valid_o out 1: short-packet request.
- sp_type_o out 2: 00 FS, 01 FE, 10 LS, 11 LE.
- sp_ready_i in 1: packetiser accepts short packet.
- pix_valid_o out 1: pixel beat valid.
- pix_ready_i in 1: packetiser accepts beat.
- line_last_o out 1: current beat is the last of the line.
- line_number_o out 12: 1..V_ACTIVE; 0 when idle.
- hori_pixel_count_o out 12: first pixel index of the current beat.
- pattern_o out 3: pattern select to the generator.
- frame_count_o out 16: completed frames, wraps.
- busy_o out 1: not in IDLE.

Behaviour:
- Reset (async): state IDLE; all outputs 0; internal frame-in-pattern counter 0.
- FSM states: IDLE, FS, LINE, HBLANK, FE, VBLANK.
- IDLE:
  - enable_i=1 -> FS next cycle.
  - Entering FS sets line_number_o=1 and hori_pixel_count_o=0.
- FS:
  - sp_valid_o=1, sp_type_o=00.
  - Holds until sp_valid_o && sp_ready_i, then -> LINE.
- LINE:
  - pix_valid_o=1.
  - On each accepted beat, hori_pixel_count_o += PIX_PER_CLK.
  - line_last_o=1 while hori_pixel_count_o == H_ACTIVE-PIX_PER_CLK.
  - Accepting the last beat -> HBLANK.
  - Outputs stay stable while pix_ready_i=0, including over multi-cycle stalls.
- HBLANK:
  - Lasts exactly H_BLANK_CLKS cycles, pix_valid_o=0; hori_pixel_count_o resets to 0 on entry.
  - At the end: if line_number_o < V_ACTIVE, line_number_o increments -> LINE; otherwise -> FE.
- FE:
  - sp_type_o=01; waits for handshake.
  - On acceptance: frame_count_o increments.
  - Pattern update on acceptance: if frame-in-pattern == FRAMES_PER_PATTERN-1, clear it and advance pattern_o with wrap; otherwise increment frame-in-pattern.
  - Then -> VBLANK.
- pattern_o changes only at FE acceptance, so it never changes mid-frame.
- VBLANK:
  - Lasts exactly V_BLANK_CLKS cycles; line_number_o=0.
  - At the end: enable_i=1 -> FS, else -> IDLE.
- enable_i deassertion is sampled only in IDLE and at the end of VBLANK; it never truncates a frame.
- Handshake rules:
  - Valid never drops before acceptance.
  - sp_valid_o and pix_valid_o are never asserted together.
  - sp_type_o is stable while sp_valid_o=1.
- Latency: the first beat of line 1 is presented the cycle after FS acceptance.
- Width: counters are 12 bits and must not overflow; parameters are constrained so H_ACTIVE, V_ACTIVE ≤ 4095.

Optional Feature:
- Macro LINE_SHORT_PKT_EN.
- When defined, adds states LS and LE:
  - FS and HBLANK go to LS (sp_type_o=10) before every line; LS acceptance -> LINE.
  - The last accepted beat goes to LE (sp_type_o=11); LE acceptance -> HBLANK.
- When undefined: no LS/LE packets and sp_type_o is never 1x; timing is as above.

Decomposition:
- Package csi2_timing_pkg holds:
  - FSM state enum;
  - short-packet type constants SP_FS, SP_FE, SP_LS, SP_LE;
  - 12-bit line/pixel count typedef.
- Sub-module blank_cycle_counter: loadable down-counter with done pulse, shared by HBLANK and VBLANK.

Test Plan:
- Small config (H_ACTIVE=8, PIX_PER_CLK=4, V_ACTIVE=3, H_BLANK_CLKS=2, V_BLANK_CLKS=5), ready tied high, enable high:
  - expected order: FS, then per line hori counts 0,4 with line_last_o on 4;
  - line numbers 1,2,3, then FE;
  - frame period = 1+3*(2+2)+1+5 = 19 cycles per frame.
- Random pix_ready_i/sp_ready_i stalls -> valid held, counts stable, no dropped or duplicate beats; beat total equals 2*3 per frame.
- FRAMES_PER_PATTERN=2, NUM_PATTERNS=4 -> pattern_o sequence 0,0,1,1,2,2,3,3,0, changing only at FE acceptance.
- enable_i dropped during line 2 -> frame completes with FE, then VBLANK, then IDLE; busy_o=0 afterwards; no new FS.
- reset_i asserted mid-LINE asynchronously -> all outputs 0 before the next edge; restart begins with FS, line 1, pattern 0.
- LINE_SHORT_PKT_EN defined -> each line is framed LS ... LE; sp_type_o sequence is FS, LS, LE, LS, LE, LS, LE, FE.
